// File: rtl/gh_video_gen.sv
// gh_video_gen: synthetic raster source painting five fret boxes lit by a scripted note stream.
// Video outputs are registered one cycle behind the counters; notes switch only at frame boundaries.
module gh_video_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b1,
    parameter int BOX      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Enable,
    input  logic [23:0] GreenPos,
    input  logic [23:0] RedPos,
    input  logic [23:0] YellowPos,
    input  logic [23:0] BluePos,
    input  logic [23:0] OrangePos,
    input  logic [23:0] ColourOn,
    input  logic [23:0] ColourOff,
    input  logic [23:0] Background,
    input  logic [4:0]  NoteFrets,
    input  logic [3:0]  NoteFrames,
    input  logic        NoteLoad,
    output logic        NoteReady,
    output logic [4:0]  NoteActive,
    output logic        HSync,
    output logic        VSync,
    output logic        VDE,
    output logic [23:0] RGB,
    output logic [15:0] FrameCount
);
    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] HL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VA  = 12'(V_ACTIVE);
    localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] VL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] BE  = 12'(BOX - 1);

    logic [11:0]      h_cnt, v_cnt;
    logic [4:0][23:0] pos;
    logic             active, last, hit;
    logic [2:0]       lane;
    logic [23:0]      pix;
    logic             pend_valid;
    logic [4:0]       pend_frets;
    logic [3:0]       pend_frames, hold;

    assign pos = {OrangePos, BluePos, YellowPos, RedPos, GreenPos};
    assign NoteReady = !pend_valid;

    // Lanes scanned high to low so the lowest-index hit is the one left standing.
    always_comb begin
        active = h_cnt < HA && v_cnt < VA;
        last = h_cnt == HL && v_cnt == VL;
        hit = 1'b0;
        lane = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (h_cnt >= {1'b0, pos[i][10:0]} && h_cnt <= {1'b0, pos[i][10:0]} + BE &&
                v_cnt >= {2'b0, pos[i][21:12]} && v_cnt <= {2'b0, pos[i][21:12]} + BE) begin
                hit = 1'b1;
                lane = 3'(i);
            end
        pix = !active ? 24'd0 : !hit ? Background : NoteActive[lane] ? ColourOn : ColourOff;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
            HSync <= ~SYNC_POL;
            VSync <= ~SYNC_POL;
            VDE <= 1'b0;
            RGB <= '0;
            FrameCount <= '0;
            NoteActive <= '0;
            hold <= '0;
            pend_valid <= 1'b0;
            pend_frets <= '0;
            pend_frames <= '0;
        end else begin
            if (Enable) begin
                h_cnt <= h_cnt == HL ? 12'd0 : h_cnt + 12'd1;
                if (h_cnt == HL)
                    v_cnt <= v_cnt == VL ? 12'd0 : v_cnt + 12'd1;
                HSync <= (h_cnt >= HS0 && h_cnt < HS1) ? SYNC_POL : ~SYNC_POL;
                VSync <= (v_cnt >= VS0 && v_cnt < VS1) ? SYNC_POL : ~SYNC_POL;
                VDE <= active;
                RGB <= pix;
            end else begin
                h_cnt <= '0;
                v_cnt <= '0;
                HSync <= ~SYNC_POL;
                VSync <= ~SYNC_POL;
                VDE <= 1'b0;
                RGB <= '0;
            end
            if (NoteLoad && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_frets <= NoteFrets;
                pend_frames <= NoteFrames;
            end
            // A waiting note takes the boundary even if the current one expires there.
            if (Enable && last) begin
                FrameCount <= FrameCount + 16'd1;
                if (pend_valid) begin
                    NoteActive <= pend_frets;
                    hold <= pend_frames == 4'd0 ? 4'd1 : pend_frames;
                    pend_valid <= 1'b0;
                end else if (hold != 4'd0) begin
                    hold <= hold - 4'd1;
                    if (hold == 4'd1)
                        NoteActive <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gh_video_gen.sv
// tb_gh_video_gen: randomized frames checked against a linear-pixel-index reference model.
module tb_gh_video_gen;
    localparam int HA = 20, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
    localparam int BX = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [23:0] gp, rp, yp, bp, op, con, coff, bg;
    logic [4:0]  nf = '0;
    logic [3:0]  nfr = '0;
    logic        nl = 1'b0;
    logic        ready, hs, vs, vde;
    logic [4:0]  act;
    logic [23:0] rgb;
    logic [15:0] fc;

    gh_video_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b1), .BOX(BX)
    ) dut (
        .CLK(clk), .RST(rst), .Enable(en),
        .GreenPos(gp), .RedPos(rp), .YellowPos(yp), .BluePos(bp), .OrangePos(op),
        .ColourOn(con), .ColourOff(coff), .Background(bg),
        .NoteFrets(nf), .NoteFrames(nfr), .NoteLoad(nl),
        .NoteReady(ready), .NoteActive(act),
        .HSync(hs), .VSync(vs), .VDE(vde), .RGB(rgb), .FrameCount(fc)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;

    int          p, m_hold, m_pn;
    logic [4:0]  m_act, m_pf;
    bit          m_pv;
    logic [15:0] m_fc;
    bit          e_hs, e_vs, e_vde;
    logic [23:0] e_rgb;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] mkpos(int x, int y);
        return {2'b0, 10'(y), 1'b0, 11'(x)};
    endfunction

    function automatic logic [23:0] pixel(int h, int v);
        logic [23:0] lp [5];
        lp = '{gp, rp, yp, bp, op};
        for (int i = 0; i < 5; i++) begin
            int x = int'(lp[i][10:0]);
            int y = int'(lp[i][21:12]);
            if (h >= x && h < x + BX && v >= y && v < y + BX)
                return m_act[i] ? con : coff;
        end
        return bg;
    endfunction

    task automatic step();
        bit was_ready, bnd;
        int h, v;
        if (rst) begin
            {e_hs, e_vs, e_vde} = '0;
            e_rgb = '0;
            p = 0; m_act = '0; m_hold = 0; m_pv = 0; m_fc = '0;
        end else begin
            was_ready = !m_pv;
            bnd = 0;
            if (en) begin
                h = p % HT;
                v = p / HT;
                e_vde = h < HA && v < VA;
                e_hs = h >= HA + HFP && h < HA + HFP + HS;
                e_vs = v >= VA + VFP && v < VA + VFP + VS;
                e_rgb = e_vde ? pixel(h, v) : 24'd0;
                bnd = p == FT - 1;
                p = (p + 1) % FT;
            end else begin
                {e_hs, e_vs, e_vde} = '0;
                e_rgb = '0;
                p = 0;
            end
            if (bnd) begin
                m_fc++;
                if (m_pv) begin
                    m_act = m_pf;
                    m_hold = m_pn == 0 ? 1 : m_pn;
                    m_pv = 0;
                end else if (m_hold > 0) begin
                    m_hold--;
                    if (m_hold == 0) m_act = '0;
                end
            end
            if (nl && was_ready) begin
                m_pv = 1; m_pf = nf; m_pn = int'(nfr);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        step();
        #1;
        check("hsync", hs, e_hs);
        check("vsync", vs, e_vs);
        check("vde", vde, e_vde);
        check("rgb", rgb, e_rgb);
        check("frames", fc, m_fc);
        check("ready", ready, !m_pv);
        check("active", act, m_act);
    endtask

    task automatic wait_boundary();
        logic [15:0] f0 = fc;
        int n = 0;
        while (fc == f0 && n < 2 * FT) begin
            cyc();
            n++;
        end
        check("boundary_timeout", fc != f0, 1);
    endtask

    initial begin
        int pixels, blue, hsw;
        gp = mkpos(2040, 0); rp = mkpos(2040, 0); yp = mkpos(2040, 0);
        bp = mkpos(2040, 0); op = mkpos(2040, 0);
        con = 24'hFF0000; coff = 24'h0000FF; bg = 24'h000000;
        repeat (3) cyc();
        check("rst_hsync", hs, 0);
        check("rst_vsync", vs, 0);
        check("rst_vde", vde, 0);
        check("rst_rgb", rgb, 0);
        check("rst_frames", fc, 0);
        check("rst_ready", ready, 1);
        check("rst_active", act, 0);

        rst = 1'b0;
        gp = mkpos(5, 3);
        pixels = 0; blue = 0; hsw = 0;
        for (int c = 0; c < FT; c++) begin
            cyc();
            if (c == 0) check("first_vde", vde, 1);
            pixels += vde;
            blue += (vde && rgb == 24'h0000FF);
            if (c < HT) hsw += hs;
        end
        check("vde_count", pixels, HA * VA);
        check("box_pixels", blue, BX * BX);
        check("hsync_width", hsw, HS);
        check("one_frame", fc, 1);

        check("idle_ready", ready, 1);
        repeat (37) cyc();
        nl = 1; nf = 5'b00101; nfr = 4'd3;
        cyc();
        nf = 5'b11010; nfr = 4'd1;
        cyc();
        nl = 0;
        check("ready_low", ready, 0);
        wait_boundary();
        check("note_lit", act, 5'b00101);
        check("ready_back", ready, 1);
        repeat (3 * FT - 1) cyc();
        check("note_still_lit", act, 5'b00101);
        cyc();
        check("note_expired", act, 5'b00000);

        rp = mkpos(HA - 2, 4);
        gp = mkpos(HA - 3, 4);
        nl = 1; nf = 5'b00010; nfr = 4'd2;
        cyc();
        nl = 0;
        wait_boundary();
        repeat (FT) cyc();

        for (int f = 0; f < 30; f++) begin
            for (int c = 0; c < FT; c++) begin
                if (c == 0) begin
                    logic [23:0] np [5];
                    for (int i = 0; i < 5; i++) begin
                        int x = $urandom_range(0, HA + 1);
                        int y = $urandom_range(0, VA + 1);
                        if ($urandom_range(0, 9) == 0) x = 2040 + $urandom_range(0, 7);
                        if ($urandom_range(0, 9) == 0) y = 1020 + $urandom_range(0, 3);
                        np[i] = mkpos(x, y);
                    end
                    {gp, rp, yp, bp, op} = {np[0], np[1], np[2], np[3], np[4]};
                    con = $urandom; coff = $urandom; bg = $urandom;
                end
                en = !(f % 5 == 4 && $urandom_range(0, 99) == 0);
                nl = $urandom_range(0, 99) < 4;
                nf = 5'($urandom);
                nfr = 4'($urandom_range(0, 3));
                if (f == 25 && c == 7 * HT + 3) begin
                    nl = 1'b1;
                    cyc();
                    nl = 1'b0;
                    rst = 1'b1;
                    cyc();
                    check("midrst_ready", ready, 1);
                    check("midrst_vde", vde, 0);
                    check("midrst_active", act, 0);
                    rst = 1'b0;
                end
                cyc();
            end
        end
        en = 1'b1; nl = 1'b0;
        repeat (FT) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/gh_video_gen.md
# gh_video_gen

Synthetic video source that drives the same HSync/VSync/VDE/RGB interface the fret-detection player consumes. It paints five fret target boxes at programmable positions, lit or unlit according to a note script fed over a ready/load handshake. The bench and on-board self-test use it as the transmitter end of the video path, so fret, strum and delay logic can be exercised with cycle-exact, repeatable frames instead of captured HDMI.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 1, asserted level of HSync/VSync
- BOX, 8, fret box edge length in pixels

Ports:
- CLK  in  1  pixel clock (the video PClk domain)
- RST  in  1  synchronous, active-high reset
- Enable  in  1  run timing; low = idle
- GreenPos, RedPos, YellowPos, BluePos, OrangePos  in  24 each  box top-left; x = [10:0], y = [21:12]
- ColourOn  in  24  RGB of a lit box
- ColourOff  in  24  RGB of an unlit box
- Background  in  24  RGB of all other active pixels
- NoteFrets  in  5  {O,B,Y,R,G} lanes to light
- NoteFrames  in  4  frames to display the note; 0 is treated as 1
- NoteLoad  in  1  note strobe
- NoteReady  out  1  pending slot empty
- NoteActive  out  5  lanes currently lit
- HSync  out  1  horizontal sync
- VSync  out  1  vertical sync
- VDE  out  1  data enable
- RGB  out  24  pixel
- FrameCount  out  16  completed frames

## Operation
- Counters hCnt (0..HT-1, HT = sum of H params) and vCnt (0..VT-1). hCnt advances every CLK while Enable is high. vCnt advances when hCnt wraps. Both wrap to 0 together at frame end.
- Line order: active, FP, sync, BP. Frame order is the same, in lines.
- HSync is asserted iff H_ACTIVE+H_FP ≤ hCnt < H_ACTIVE+H_FP+H_SYNC. VSync is asserted iff vCnt is in the sync lines, for whole lines. VDE = hCnt<H_ACTIVE && vCnt<V_ACTIVE.
- Box hit for lane i: x ≤ hCnt ≤ x+BOX-1 and y ≤ vCnt ≤ y+BOX-1.
  - Sums are computed in 12 bits with no wrap.
  - Boxes extending past the active area are clipped.
  - Overlapping boxes: the lowest lane index wins (G > R > Y > B > O).
- RGB: 0 when VDE is low. When VDE is high: ColourOn if the hit lane is in NoteActive, ColourOff if the hit lane is not in NoteActive, otherwise Background.
- Note handshake:
  - NoteLoad is sampled only while NoteReady=1. It captures NoteFrets and NoteFrames into the pending slot, and NoteReady drops on the next edge.
  - NoteLoad while NoteReady=0 is ignored; the pending slot is unchanged.
- Frame boundary (counters wrapping to 0,0):
  - FrameCount increments, wrapping at 16 bits.
  - If the hold counter is nonzero, it decrements. When it reaches 0, NoteActive clears to 0.
  - If pending is valid, NoteActive ← pending frets, hold ← max(NoteFrames,1), pending is emptied, and NoteReady rises. This overrides any expiry on the same boundary.
  - NoteActive changes only at frame boundaries, never mid-frame.
- NoteLoad coinciding with a boundary that empties the slot: no load occurs that cycle, because NoteReady was 0 when sampled.
- Enable low:
  - Counters are forced to 0, syncs deasserted, VDE=0, RGB=0, FrameCount held.
  - The note handshake still operates; pending and NoteActive are retained.
- Enable rising: timing restarts at (0,0). No frame boundary is counted.

## Timing
- All video outputs are registered, 1 cycle after the counters; HSync, VSync, VDE and RGB are mutually aligned.
- Reset values: HSync=VSync=~SYNC_POL, VDE=0, RGB=0, FrameCount=0, NoteReady=1, NoteActive=0. Counters, pending and hold are cleared.
- With Enable held high, the first CLK edge with RST low presents pixel (0,0): VDE=1 from that cycle.
- Reset asserted mid-frame takes effect on the next edge and discards any pending note.
- Default frame: 800×525 = 420000 cycles. The HSync edge comes 656 cycles after line start; the VSync edge comes 490 lines after frame start.

## Test plan
- Defaults, no notes: VDE high 640 of every 800 cycles, 480 of 525 lines; HSync 96 cycles wide; VSync 2 lines wide; FrameCount=1 after 420000 cycles.
- GreenPos x=100,y=200, ColourOff=0x0000FF, Background=0: 64 pixels of 0x0000FF at x 100..107, y 200..207 per frame; all other active pixels 0.
- NoteLoad mid-frame, frets=5'b00101, NoteFrames=3: NoteReady low until the next boundary; G and Y lit for exactly 3 frames, then NoteActive=0.
- NoteLoad asserted twice back-to-back with different frets: the second is ignored; only the first is displayed.
- Red box at x=636 and Green box overlapping Red: the Red box is clipped at x=639, and the overlap pixels show Green's colour.
- RST pulsed at line 300 with a note pending: next edge shows reset values; output restarts at (0,0); NoteReady=1 and the pending note is lost.
